// File: rtl/dds_pkg.sv
// Shared MIDI-over-SPI constants: status nibbles, frame length, master FSM encoding.
package dds_pkg;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam int         FRAME_LEN     = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOW     = 3'd1,
    ST_HIGH    = 3'd2,
    ST_GAP     = 3'd3,
    ST_TAIL    = 3'd4,
    ST_RECOVER = 3'd5
  } spi_state_e;

  function automatic logic [7:0] midi_status(input logic note_on, input logic [3:0] channel);
    return {(note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), channel};
  endfunction

endpackage

// File: rtl/midi_spi_master_if.sv
// Event handshake, SPI pins and MISO capture of the MIDI SPI master, grouped for port passing.
interface midi_spi_master_if;

  logic       msg_valid;
  logic       msg_ready;
  logic       msg_note_on;
  logic [3:0] msg_channel;
  logic [6:0] msg_note;
  logic [6:0] msg_velocity;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_nss;
  logic       spi_miso;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       busy;

  modport slave (
    input  msg_valid, msg_note_on, msg_channel, msg_note, msg_velocity, spi_miso,
    output msg_ready, spi_sclk, spi_mosi, spi_nss, rx_byte, rx_byte_valid, busy
  );

  modport master (
    output msg_valid, msg_note_on, msg_channel, msg_note, msg_velocity, spi_miso,
    input  msg_ready, spi_sclk, spi_mosi, spi_nss, rx_byte, rx_byte_valid, busy
  );

endinterface

// File: rtl/spi_byte_shifter.sv
// 8-bit MOSI/MISO shift pair; MOSI is the MSB of the transmit register.
// Strobe-driven only: the parent FSM decides when to load, capture and shift.
module spi_byte_shifter (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_dat_i,
  input  logic       shift_i,
  input  logic       capture_i,
  input  logic       miso_i,
  output logic       mosi_o,
  output logic [7:0] rx_dat_o
);

  logic [7:0] tx_q;
  logic [7:0] rx_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load_i) begin
        tx_q <= load_dat_i;
      end else if (shift_i) begin
        tx_q <= {tx_q[6:0], 1'b0};
      end
      if (capture_i) begin
        rx_q <= {rx_q[6:0], miso_i};
      end
    end
  end

  assign mosi_o   = tx_q[7];
  assign rx_dat_o = rx_q;

endmodule

// File: rtl/midi_spi_master.sv
// Sends each accepted MIDI note event as a 3-byte mode-0 SPI frame and returns the MISO bytes.
// One event in flight: msg_ready is high only in IDLE, so a new event waits until the frame recovers.
module midi_spi_master
  import dds_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int BYTE_GAP = 4
) (
  input logic              clk,
  input logic              reset,
  midi_spi_master_if.slave bus_if
);

  localparam int          DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int          GAP_W     = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
  localparam logic [1:0]  LAST_BYTE = 2'(FRAME_LEN - 1);

  spi_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic             sclk_q, sclk_d;
  logic             nss_q, nss_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_vld_q, rx_vld_d;
  logic [6:0]       note_q, note_d;
  logic [6:0]       vel_q, vel_d;

  logic       sh_load, sh_shift, sh_capture, sh_mosi;
  logic [7:0] sh_load_dat, sh_rx;
  logic       div_last;

  spi_byte_shifter u_shifter (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (sh_load),
    .load_dat_i (sh_load_dat),
    .shift_i    (sh_shift),
    .capture_i  (sh_capture),
    .miso_i     (bus_if.spi_miso),
    .mosi_o     (sh_mosi),
    .rx_dat_o   (sh_rx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      sclk_q    <= 1'b0;
      nss_q     <= 1'b1;
      rx_byte_q <= '0;
      rx_vld_q  <= 1'b0;
      note_q    <= '0;
      vel_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sclk_q    <= sclk_d;
      nss_q     <= nss_d;
      rx_byte_q <= rx_byte_d;
      rx_vld_q  <= rx_vld_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    sclk_d      = sclk_q;
    nss_d       = nss_q;
    rx_byte_d   = rx_byte_q;
    rx_vld_d    = 1'b0;
    note_d      = note_q;
    vel_d       = vel_q;
    sh_load     = 1'b0;
    sh_load_dat = '0;
    sh_shift    = 1'b0;
    sh_capture  = 1'b0;
    div_last    = (div_q == DIV_W'(CLK_DIV - 1));

    case (state_q)
      ST_IDLE: begin
        if (bus_if.msg_valid) begin
          // status byte goes straight into the shifter so its MSB is on MOSI as nss falls
          sh_load     = 1'b1;
          sh_load_dat = midi_status(bus_if.msg_note_on, bus_if.msg_channel);
          note_d      = bus_if.msg_note;
          vel_d       = bus_if.msg_velocity;
          nss_d       = 1'b0;
          sclk_d      = 1'b0;
          div_d       = '0;
          bit_d       = '0;
          byte_d      = '0;
          state_d     = ST_LOW;
        end
      end
      ST_LOW: begin
        if (div_last) begin
          div_d      = '0;
          sclk_d     = 1'b1;
          sh_capture = 1'b1;
          state_d    = ST_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_last) begin
          div_d    = '0;
          sclk_d   = 1'b0;
          sh_shift = 1'b1;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_LOW;
          end else begin
            bit_d     = '0;
            rx_byte_d = sh_rx;
            rx_vld_d  = 1'b1;
            if (byte_q == LAST_BYTE) begin
              state_d = ST_TAIL;
            end else begin
              byte_d  = byte_q + 2'd1;
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(BYTE_GAP - 1)) begin
          sh_load     = 1'b1;
          sh_load_dat = (byte_q == 2'd1) ? {1'b0, note_q} : {1'b0, vel_q};
          gap_d       = '0;
          div_d       = '0;
          state_d     = ST_LOW;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_TAIL: begin
        if (div_last) begin
          div_d   = '0;
          nss_d   = 1'b1;
          state_d = ST_RECOVER;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_if.msg_ready     = (state_q == ST_IDLE);
  assign bus_if.busy          = (state_q != ST_IDLE);
  assign bus_if.spi_sclk      = sclk_q;
  assign bus_if.spi_nss       = nss_q;
  assign bus_if.spi_mosi      = sh_mosi;
  assign bus_if.rx_byte       = rx_byte_q;
  assign bus_if.rx_byte_valid = rx_vld_q;

endmodule

// File: tb/tb_midi_spi_master.sv
// Directed bench for midi_spi_master with a mode-0 SPI slave model sampling MOSI on sclk rise.
module tb_midi_spi_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  midi_spi_master_if bus ();

  midi_spi_master #(.CLK_DIV(2), .BYTE_GAP(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  typedef struct {
    logic        on;
    logic [3:0]  ch;
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [23:0] miso;
    logic [23:0] exp_mosi;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // slave model state
  logic [7:0] miso_pat [3];
  logic [7:0] mosi_q [$];
  logic [7:0] rxv_q [$];
  int         nss_low_cnt = 0;
  int         rises = 0;
  logic [2:0] bitpos = '0;
  logic [1:0] bidx = '0;
  logic [7:0] shreg = '0;
  logic       sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.spi_nss !== 1'b0) begin
      bitpos = '0;
      bidx   = '0;
      shreg  = '0;
    end else begin
      nss_low_cnt++;
      if (bus.spi_sclk === 1'b1 && sclk_prev === 1'b0) begin
        shreg = {shreg[6:0], bus.spi_mosi};
        rises++;
        if (bitpos == 3'd7) begin
          mosi_q.push_back(shreg);
          bitpos = '0;
          if (bidx != 2'd2) bidx = bidx + 2'd1;
        end else begin
          bitpos = bitpos + 3'd1;
        end
      end
    end
    sclk_prev    = bus.spi_sclk;
    bus.spi_miso = miso_pat[bidx][3'd7 - bitpos];
    if (bus.rx_byte_valid === 1'b1) rxv_q.push_back(bus.rx_byte);
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (bus.msg_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(t < 2000, "ready_timeout", t, 2000);
  endtask

  task automatic send_evt(input logic on, input logic [3:0] ch, input logic [6:0] note,
                          input logic [6:0] vel);
    @(negedge clk);
    wait_ready();
    bus.msg_note_on  = on;
    bus.msg_channel  = ch;
    bus.msg_note     = note;
    bus.msg_velocity = vel;
    bus.msg_valid    = 1'b1;
    @(posedge clk);
    #1 bus.msg_valid = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    int s_m, s_r, s_n, s_k, lo;
    s_m = mosi_q.size();
    s_r = rxv_q.size();
    s_n = nss_low_cnt;
    s_k = rises;
    miso_pat[0] = v.miso[23:16];
    miso_pat[1] = v.miso[15:8];
    miso_pat[2] = v.miso[7:0];
    send_evt(v.on, v.ch, v.note, v.vel);
    lo = 0;
    @(negedge clk);
    while (bus.msg_ready !== 1'b1 && lo < 2000) begin
      lo++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk(lo == 108, {tag, "_ready_low"}, lo, 108);
    chk(nss_low_cnt - s_n == 106, {tag, "_nss_low"}, nss_low_cnt - s_n, 106);
    chk(rises - s_k == 24, {tag, "_sclk_rises"}, rises - s_k, 24);
    chk(mosi_q.size() - s_m == 3, {tag, "_mosi_count"}, mosi_q.size() - s_m, 3);
    chk(rxv_q.size() - s_r == 3, {tag, "_rx_count"}, rxv_q.size() - s_r, 3);
    for (int b = 0; b < 3; b++) begin
      logic [7:0] em, er;
      em = v.exp_mosi[23 - 8*b -: 8];
      er = v.miso[23 - 8*b -: 8];
      if (mosi_q.size() > s_m + b)
        chk(mosi_q[s_m + b] == em, {tag, "_mosi_byte"}, int'(mosi_q[s_m + b]), int'(em));
      if (rxv_q.size() > s_r + b)
        chk(rxv_q[s_r + b] == er, {tag, "_rx_byte"}, int'(rxv_q[s_r + b]), int'(er));
    end
  endtask

  vec_t vecs [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int s_m, s_r, hi, t;

    vecs[0] = '{on: 1'b1, ch: 4'h0, note: 7'd60,  vel: 7'd100, miso: 24'h00_00_00, exp_mosi: 24'h90_3C_64};
    vecs[1] = '{on: 1'b0, ch: 4'h3, note: 7'd127, vel: 7'd0,   miso: 24'hA5_5A_FF, exp_mosi: 24'h83_7F_00};
    vecs[2] = '{on: 1'b1, ch: 4'h5, note: 7'd0,   vel: 7'd0,   miso: 24'h3C_C3_81, exp_mosi: 24'h95_00_00};
    miso_pat[0] = '0;
    miso_pat[1] = '0;
    miso_pat[2] = '0;

    // reset together with msg_valid: nothing may be accepted
    reset            = 1'b1;
    bus.msg_valid    = 1'b1;
    bus.msg_note_on  = 1'b1;
    bus.msg_channel  = 4'h0;
    bus.msg_note     = 7'd1;
    bus.msg_velocity = 7'd1;
    repeat (3) @(negedge clk);
    chk(bus.busy === 1'b0, "reset_vs_valid_busy", int'(bus.busy), 0);
    chk(bus.spi_nss === 1'b1, "reset_nss", int'(bus.spi_nss), 1);
    chk(bus.spi_sclk === 1'b0, "reset_sclk", int'(bus.spi_sclk), 0);
    chk(bus.spi_mosi === 1'b0, "reset_mosi", int'(bus.spi_mosi), 0);
    chk(bus.msg_ready === 1'b1, "reset_ready", int'(bus.msg_ready), 1);
    chk(bus.rx_byte === 8'h00, "reset_rx_byte", int'(bus.rx_byte), 0);
    chk(bus.rx_byte_valid === 1'b0, "reset_rx_valid", int'(bus.rx_byte_valid), 0);
    bus.msg_valid = 1'b0;
    reset         = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.spi_nss === 1'b1, "idle_nss", int'(bus.spi_nss), 1);

    for (int i = 0; i < 3; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // two events back to back with msg_valid held high
    s_m = mosi_q.size();
    @(negedge clk);
    wait_ready();
    bus.msg_note_on  = 1'b1;
    bus.msg_channel  = 4'h0;
    bus.msg_note     = 7'h40;
    bus.msg_velocity = 7'h10;
    bus.msg_valid    = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.busy !== 1'b1 && t < 100);
    bus.msg_note_on  = 1'b0;
    bus.msg_channel  = 4'h2;
    bus.msg_note     = 7'h41;
    bus.msg_velocity = 7'h7E;
    t = 0;
    while (bus.spi_nss !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    hi = 0;
    while (bus.spi_nss === 1'b1 && hi < 500) begin @(negedge clk); hi++; end
    bus.msg_valid = 1'b0;
    chk(hi >= 2 && hi < 500, "b2b_nss_high_min", hi, 2);
    @(negedge clk);
    wait_ready();
    repeat (4) @(negedge clk);
    chk(mosi_q.size() - s_m == 6, "b2b_byte_count", mosi_q.size() - s_m, 6);
    if (mosi_q.size() >= s_m + 6) begin
      chk(mosi_q[s_m+0] == 8'h90, "b2b_b0", int'(mosi_q[s_m+0]), 8'h90);
      chk(mosi_q[s_m+1] == 8'h40, "b2b_b1", int'(mosi_q[s_m+1]), 8'h40);
      chk(mosi_q[s_m+2] == 8'h10, "b2b_b2", int'(mosi_q[s_m+2]), 8'h10);
      chk(mosi_q[s_m+3] == 8'h82, "b2b_b3", int'(mosi_q[s_m+3]), 8'h82);
      chk(mosi_q[s_m+4] == 8'h41, "b2b_b4", int'(mosi_q[s_m+4]), 8'h41);
      chk(mosi_q[s_m+5] == 8'h7E, "b2b_b5", int'(mosi_q[s_m+5]), 8'h7E);
    end

    // reset at cycle 40 of a frame
    miso_pat[0] = 8'hF0;
    miso_pat[1] = 8'h0F;
    miso_pat[2] = 8'h55;
    send_evt(1'b1, 4'h1, 7'h33, 7'h44);
    repeat (39) @(negedge clk);
    s_r   = rxv_q.size();
    reset = 1'b1;
    @(negedge clk);
    chk(bus.spi_nss === 1'b1, "midreset_nss", int'(bus.spi_nss), 1);
    chk(bus.spi_sclk === 1'b0, "midreset_sclk", int'(bus.spi_sclk), 0);
    chk(bus.busy === 1'b0, "midreset_busy", int'(bus.busy), 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk(rxv_q.size() == s_r, "midreset_no_rx_valid", rxv_q.size() - s_r, 0);
    chk(bus.rx_byte === 8'h00, "midreset_rx_byte", int'(bus.rx_byte), 0);
    run_vector(vecs[0], "after_reset");

    // fields change one cycle after accept
    s_m = mosi_q.size();
    send_evt(1'b1, 4'h0, 7'h11, 7'h22);
    @(posedge clk);
    #1;
    bus.msg_note     = 7'h6B;
    bus.msg_velocity = 7'h05;
    bus.msg_note_on  = 1'b0;
    @(negedge clk);
    wait_ready();
    repeat (4) @(negedge clk);
    chk(mosi_q.size() - s_m == 3, "late_change_count", mosi_q.size() - s_m, 3);
    if (mosi_q.size() >= s_m + 3) begin
      chk(mosi_q[s_m+0] == 8'h90, "late_change_status", int'(mosi_q[s_m+0]), 8'h90);
      chk(mosi_q[s_m+1] == 8'h11, "late_change_note", int'(mosi_q[s_m+1]), 8'h11);
      chk(mosi_q[s_m+2] == 8'h22, "late_change_vel", int'(mosi_q[s_m+2]), 8'h22);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
